// File: rtl/mask_match_sequencer_if.sv
// Bundle of job, matcher and round-beat signals around mask_match_sequencer.
// slave is the sequencer's view; master is the surrounding logic's view.
interface mask_match_sequencer_if #(
    parameter int unsigned BITMASK_LENGTH = 4,
    parameter int unsigned INDEX_BITWIDTH = 3,
    parameter int unsigned COUNT_BITWIDTH = 3,
    parameter int unsigned TOTAL_BITWIDTH = 4
);
    // Job intake from the sparse-operand buffer
    logic                      in_valid;
    logic                      in_ready;
    logic [BITMASK_LENGTH-1:0] in_bitmask_w;
    logic [BITMASK_LENGTH-1:0] in_bitmask_a;

    // Combinational matcher operands and results
    logic [BITMASK_LENGTH-1:0] mm_bitmask_w;
    logic [BITMASK_LENGTH-1:0] mm_bitmask_a;
    logic [INDEX_BITWIDTH-1:0] mm_start_w;
    logic [INDEX_BITWIDTH-1:0] mm_start_a;
    logic [BITMASK_LENGTH-1:0] mm_sel_w;
    logic [BITMASK_LENGTH-1:0] mm_sel_a;
    logic [COUNT_BITWIDTH-1:0] mm_num;
    logic [INDEX_BITWIDTH-1:0] mm_next_w;
    logic [INDEX_BITWIDTH-1:0] mm_next_a;
    logic                      mm_last;

    // Round beats toward the PE operand fetch
    logic                      out_valid;
    logic                      out_ready;
    logic [BITMASK_LENGTH-1:0] out_sel_w;
    logic [BITMASK_LENGTH-1:0] out_sel_a;
    logic [COUNT_BITWIDTH-1:0] out_num;
    logic                      out_last;
    logic [TOTAL_BITWIDTH-1:0] out_total;
    logic                      out_err;

    modport slave (
        input  in_valid, in_bitmask_w, in_bitmask_a,
        input  mm_sel_w, mm_sel_a, mm_num, mm_next_w, mm_next_a, mm_last,
        input  out_ready,
        output in_ready,
        output mm_bitmask_w, mm_bitmask_a, mm_start_w, mm_start_a,
        output out_valid, out_sel_w, out_sel_a, out_num, out_last, out_total, out_err
    );

    modport master (
        output in_valid, in_bitmask_w, in_bitmask_a,
        output mm_sel_w, mm_sel_a, mm_num, mm_next_w, mm_next_a, mm_last,
        output out_ready,
        input  in_ready,
        input  mm_bitmask_w, mm_bitmask_a, mm_start_w, mm_start_a,
        input  out_valid, out_sel_w, out_sel_a, out_num, out_last, out_total, out_err
    );
endinterface

// File: rtl/mask_match_sequencer.sv
// Walks one weight/activation bitmask pair through a combinational matcher,
// emitting one registered beat per round; the last beat carries the job total.
module mask_match_sequencer #(
    parameter int unsigned BITMASK_LENGTH = 4,
    parameter int unsigned INDEX_BITWIDTH = 3,
    parameter int unsigned COUNT_BITWIDTH = 3,
    parameter int unsigned TOTAL_BITWIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    mask_match_sequencer_if.slave  bus
);
    localparam logic [INDEX_BITWIDTH-1:0] LAST_ROUND = INDEX_BITWIDTH'(BITMASK_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EVAL    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_in_ready;
    logic [BITMASK_LENGTH-1:0] r_mask_w;
    logic [BITMASK_LENGTH-1:0] r_mask_a;
    logic [INDEX_BITWIDTH-1:0] r_start_w;
    logic [INDEX_BITWIDTH-1:0] r_start_a;
    logic [INDEX_BITWIDTH-1:0] r_next_w;
    logic [INDEX_BITWIDTH-1:0] r_next_a;
    logic [INDEX_BITWIDTH-1:0] r_round;
    logic [TOTAL_BITWIDTH-1:0] r_acc;
    logic                      r_out_valid;
    logic [BITMASK_LENGTH-1:0] r_sel_w;
    logic [BITMASK_LENGTH-1:0] r_sel_a;
    logic [COUNT_BITWIDTH-1:0] r_num;
    logic                      r_last;
    logic [TOTAL_BITWIDTH-1:0] r_total;
    logic                      r_err;

    logic                      w_accept;
    logic                      w_handshake;
    logic                      w_stall;
    logic                      w_overrun;
    logic [TOTAL_BITWIDTH-1:0] w_total_next;

    // r_in_ready is only ever set while idle, so it doubles as the IDLE qualifier
    assign w_accept     = r_in_ready & bus.in_valid;
    assign w_handshake  = r_out_valid & bus.out_ready;
    assign w_stall      = (bus.mm_num == '0) & ~bus.mm_last;
    assign w_overrun    = (r_round == LAST_ROUND) & ~bus.mm_last;
    assign w_total_next = r_acc + TOTAL_BITWIDTH'(bus.mm_num);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_mask_w    <= '0;
            r_mask_a    <= '0;
            r_start_w   <= '0;
            r_start_a   <= '0;
            r_next_w    <= '0;
            r_next_a    <= '0;
            r_round     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_sel_w     <= '0;
            r_sel_a     <= '0;
            r_num       <= '0;
            r_last      <= 1'b0;
            r_total     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_mask_w   <= bus.in_bitmask_w;
                        r_mask_a   <= bus.in_bitmask_a;
                        r_start_w  <= '0;
                        r_start_a  <= '0;
                        r_round    <= '0;
                        r_acc      <= '0;
                        r_state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_sel_w     <= bus.mm_sel_w;
                    r_sel_a     <= bus.mm_sel_a;
                    r_num       <= bus.mm_num;
                    r_next_w    <= bus.mm_next_w;
                    r_next_a    <= bus.mm_next_a;
                    r_acc       <= w_total_next;
                    r_total     <= w_total_next;
                    r_round     <= r_round + INDEX_BITWIDTH'(1);
                    r_last      <= bus.mm_last | w_stall | w_overrun;
                    r_err       <= w_stall | w_overrun;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    // Beat and start indices are frozen until the downstream accepts
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_last) begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_start_w <= r_next_w;
                            r_start_a <= r_next_a;
                            r_state   <= S_EVAL;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.mm_bitmask_w = r_mask_w;
    assign bus.mm_bitmask_a = r_mask_a;
    assign bus.mm_start_w   = r_start_w;
    assign bus.mm_start_a   = r_start_a;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sel_w    = r_sel_w;
    assign bus.out_sel_a    = r_sel_a;
    assign bus.out_num      = r_num;
    assign bus.out_last     = r_last;
    assign bus.out_total    = r_total;
    assign bus.out_err      = r_err;
endmodule

// File: tb/tb_mask_match_sequencer.sv
// Directed bench for mask_match_sequencer with a behavioural positional matcher
// whose per-round limit and fault modes are set by each scenario.
module tb_mask_match_sequencer;
    localparam int unsigned L  = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int mm_max = 4;
    int mode   = 0;   // 0 normal, 1 forced stall, 2 forced overrun

    mask_match_sequencer_if bus ();

    mask_match_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Matcher model: pairs sit at common set positions, scanned upward from start_w
    logic [L-1:0] m_both;
    logic [L-1:0] m_sel;
    int           m_cnt;
    int           m_nxt;
    logic         m_rem;
    always_comb begin
        m_both = bus.mm_bitmask_w & bus.mm_bitmask_a;
        m_sel  = '0;
        m_cnt  = 0;
        m_nxt  = L;
        m_rem  = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (i >= int'(bus.mm_start_w) && m_both[i]) begin
                if (m_cnt < mm_max) begin
                    m_sel[i] = 1'b1;
                    m_cnt    = m_cnt + 1;
                    m_nxt    = i + 1;
                end else begin
                    m_rem = 1'b1;
                end
            end
        end
        bus.mm_sel_w  = m_sel;
        bus.mm_sel_a  = m_sel;
        bus.mm_next_w = IW'(m_nxt);
        bus.mm_next_a = IW'(m_nxt);
        bus.mm_num    = CW'(m_cnt);
        bus.mm_last   = ~m_rem;
        if (mode == 1) begin
            bus.mm_num  = '0;
            bus.mm_last = 1'b0;
        end else if (mode == 2) begin
            bus.mm_num  = CW'(1);
            bus.mm_last = 1'b0;
        end
    end

    wire [23:0] obs_vec = {bus.out_valid, bus.out_sel_w, bus.out_sel_a, bus.out_num,
                           bus.out_last, bus.out_total, bus.out_err,
                           bus.mm_start_w, bus.mm_start_a};

    // Called at a negedge; returns just after the accept edge (sequencer in EVAL)
    task automatic start_job(input logic [L-1:0] w, input logic [L-1:0] a);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_job_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid     = 1'b1;
        bus.in_bitmask_w = w;
        bus.in_bitmask_a = a;
        @(posedge clock);
        #1;
        bus.in_valid     = 1'b0;
        bus.in_bitmask_w = '0;
        bus.in_bitmask_a = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_total, bus.out_last, bus.out_err, bus.mm_start_w} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b total=%0d last=%b err=%b start=%0d required all 0",
                     bus.in_ready, bus.out_valid, bus.out_total, bus.out_last, bus.out_err, bus.mm_start_w);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single_round();
        mm_max = 4;
        start_job(4'b1011, 4'b1110);
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_eval_cycle: out_valid=%b required 0", bus.out_valid);
        end
        @(negedge clock);
        checks++;
        if ({bus.out_valid, bus.out_sel_w, bus.out_sel_a, bus.out_num, bus.out_last, bus.out_total, bus.out_err}
            !== {1'b1, 4'b1010, 4'b1010, 3'd2, 1'b1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_beat: valid=%b sw=%b sa=%b num=%0d last=%b total=%0d err=%b required 1 1010 1010 2 1 2 0",
                     bus.out_valid, bus.out_sel_w, bus.out_sel_a, bus.out_num, bus.out_last, bus.out_total, bus.out_err);
        end
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_return_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    // W=A=1111 with one match per round; bp stalls beat 2 for five cycles
    task automatic run_full_job(input bit bp);
        int             beat;
        int             evals;
        logic [IW-1:0]  starts [4];
        logic [16:0]    got;
        logic [16:0]    exp;
        logic [23:0]    snap;
        beat  = 0;
        evals = 0;
        for (int i = 0; i < 4; i++) starts[i] = '1;
        mm_max        = 1;
        bus.out_ready = 1'b1;
        start_job(4'b1111, 4'b1111);
        for (int cyc = 0; cyc < 60 && beat < 4; cyc++) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) begin
                beat++;
                got = {bus.out_sel_w, bus.out_sel_a, bus.out_num, bus.out_last, bus.out_total, bus.out_err};
                exp = {4'(1 << (beat - 1)), 4'(1 << (beat - 1)), 3'd1, (beat == 4), 4'(beat), 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL multi_beat%0d: got %h required %h", beat, got, exp);
                end
                if (bp && beat == 2) begin
                    bus.out_ready = 1'b0;
                    snap = obs_vec;
                    for (int k = 0; k < 5; k++) begin
                        bus.in_valid     = (k % 2 == 0);
                        bus.in_bitmask_w = 4'b0011;
                        bus.in_bitmask_a = 4'b0110;
                        @(negedge clock);
                        checks++;
                        if (obs_vec !== snap || bus.in_ready !== 1'b0 || bus.mm_bitmask_w !== 4'b1111) begin
                            errors++;
                            $display("FAIL backpressure_hold%0d: obs=%h in_ready=%b mask_w=%b required %h 0 1111",
                                     k, obs_vec, bus.in_ready, bus.mm_bitmask_w, snap);
                        end
                    end
                    bus.in_valid     = 1'b0;
                    bus.in_bitmask_w = '0;
                    bus.in_bitmask_a = '0;
                    bus.out_ready    = 1'b1;
                end
            end else if (bus.in_ready === 1'b0) begin
                if (evals < 4) starts[evals] = bus.mm_start_w;
                evals++;
            end
        end
        checks++;
        if (beat != 4 || evals != 4) begin
            errors++;
            $display("FAIL multi_counts: beats=%0d evals=%0d required 4 4", beat, evals);
        end
        checks++;
        if ({starts[0], starts[1], starts[2], starts[3]} !== {3'd0, 3'd1, 3'd2, 3'd3}) begin
            errors++;
            $display("FAIL multi_starts: got %0d %0d %0d %0d required 0 1 2 3",
                     starts[0], starts[1], starts[2], starts[3]);
        end
    endtask

    task automatic test_multi_round();
        run_full_job(1'b0);
    endtask

    task automatic test_backpressure();
        run_full_job(1'b1);
    endtask

    task automatic test_zero_match();
        int c;
        mm_max = 4;
        start_job(4'b0101, 4'b1010);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (bus.out_valid !== 1'b1 && c < 20);
        checks++;
        if ({bus.out_valid, bus.out_sel_w, bus.out_sel_a, bus.out_num, bus.out_last, bus.out_total, bus.out_err}
            !== {1'b1, 4'b0, 4'b0, 3'd0, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_beat: valid=%b sw=%b sa=%b num=%0d last=%b total=%0d err=%b required 1 0 0 0 1 0 0",
                     bus.out_valid, bus.out_sel_w, bus.out_sel_a, bus.out_num, bus.out_last, bus.out_total, bus.out_err);
        end
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready_after: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_stall();
        int c;
        mm_max = 4;
        mode   = 1;
        start_job(4'b0011, 4'b0011);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (bus.out_valid !== 1'b1 && c < 20);
        checks++;
        if ({bus.out_valid, bus.out_num, bus.out_last, bus.out_total, bus.out_err} !== {1'b1, 3'd0, 1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL stall_beat: valid=%b num=%0d last=%b total=%0d err=%b required 1 0 1 0 1",
                     bus.out_valid, bus.out_num, bus.out_last, bus.out_total, bus.out_err);
        end
        @(negedge clock);
        mode = 0;
    endtask

    task automatic test_overrun();
        int beat;
        mm_max = 1;
        mode   = 2;
        beat   = 0;
        start_job(4'b1111, 4'b1111);
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) begin
                beat++;
                checks++;
                if ({bus.out_last, bus.out_err, bus.out_total} !== {(beat == 4), (beat == 4), 4'(beat)}) begin
                    errors++;
                    $display("FAIL overrun_beat%0d: last=%b err=%b total=%0d required %b %b %0d",
                             beat, bus.out_last, bus.out_err, bus.out_total, (beat == 4), (beat == 4), beat);
                end
                if (bus.out_last === 1'b1) break;
            end
        end
        checks++;
        if (beat != 4) begin
            errors++;
            $display("FAIL overrun_beats: got %0d required 4", beat);
        end
        @(negedge clock);
        mode = 0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.out_total} !== {1'b1, 1'b0, 1'b1, 4'd4}) begin
            errors++;
            $display("FAIL overrun_hold_idle: ready=%b valid=%b err=%b total=%0d required 1 0 1 4",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.out_total);
        end
    endtask

    task automatic test_reset_mid_job();
        int beat;
        int c;
        mm_max        = 1;
        bus.out_ready = 1'b1;
        beat          = 0;
        start_job(4'b1111, 4'b1111);
        for (int cyc = 0; cyc < 40 && beat < 2; cyc++) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) beat++;
        end
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (beat != 2 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: beats=%0d out_valid=%b in_ready=%b required 2 0 0",
                     beat, bus.out_valid, bus.in_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.mm_start_w} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midreset_idle: in_ready=%b out_valid=%b start=%0d required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.mm_start_w);
        end
        bus.out_ready = 1'b1;
        mm_max        = 4;
        start_job(4'b0001, 4'b0001);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (bus.out_valid !== 1'b1 && c < 20);
        checks++;
        if ({bus.out_valid, bus.out_num, bus.out_last, bus.out_total, bus.out_err} !== {1'b1, 3'd1, 1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL midreset_newjob: valid=%b num=%0d last=%b total=%0d err=%b required 1 1 1 1 0",
                     bus.out_valid, bus.out_num, bus.out_last, bus.out_total, bus.out_err);
        end
        @(negedge clock);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_bitmask_w = '0;
        bus.in_bitmask_a = '0;
        bus.out_ready    = 1'b1;
        test_reset();
        test_single_round();
        test_multi_round();
        test_zero_match();
        test_backpressure();
        test_stall();
        test_overrun();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mask_match_sequencer.md
Name: mask_match_sequencer

Overview:
- Drives one combinational clMaskMatcher instance through one complete weight/activation bitmask pair.
- Accepts a job, presents the latched bitmasks and running start indices to the matcher, and captures each round's result.
- Emits one output beat per round to the downstream PE operand fetch; the final beat is flagged last and carries the total match count.
- Sits between the sparse-operand buffer (job source) and the PE's operand-select logic.

Parameters:
- BITMASK_LENGTH, 4, bits per bitmask; must match the matcher instance.
- INDEX_BITWIDTH, 3, width of start/next indices; holds 0..BITMASK_LENGTH.
- COUNT_BITWIDTH, 3, width of per-round match count; holds 0..MAX_NUM_OUTPUT.
- MAX_NUM_OUTPUT, 4, maximum matches the matcher reports per round.
- TOTAL_BITWIDTH, 4, width of the per-job total match counter; holds 0..BITMASK_LENGTH.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  job valid.
- in_ready  out  1  job accept; 1 only in IDLE.
- in_bitmask_w  in  BITMASK_LENGTH  weight bitmask.
- in_bitmask_a  in  BITMASK_LENGTH  activation bitmask.
- mm_bitmask_w  out  BITMASK_LENGTH  latched W mask to matcher.
- mm_bitmask_a  out  BITMASK_LENGTH  latched A mask to matcher.
- mm_start_w  out  INDEX_BITWIDTH  current W start index.
- mm_start_a  out  INDEX_BITWIDTH  current A start index.
- mm_sel_w  in  BITMASK_LENGTH  W positions selected this round.
- mm_sel_a  in  BITMASK_LENGTH  A positions selected this round.
- mm_num  in  COUNT_BITWIDTH  matched pairs this round.
- mm_next_w  in  INDEX_BITWIDTH  next W start index.
- mm_next_a  in  INDEX_BITWIDTH  next A start index.
- mm_last  in  1  no matches remain beyond this round.
- out_valid  out  1  round beat valid.
- out_ready  in  1  downstream accept.
- out_sel_w  out  BITMASK_LENGTH  registered mm_sel_w.
- out_sel_a  out  BITMASK_LENGTH  registered mm_sel_a.
- out_num  out  COUNT_BITWIDTH  registered mm_num.
- out_last  out  1  final beat of the job.
- out_total  out  TOTAL_BITWIDTH  cumulative matches including this beat; valid on every beat.
- out_err  out  1  job terminated by protection logic; qualified by out_last.

Behaviour:
- Reset (async): state=IDLE; all outputs, start indices, round counter and total counter = 0; in_ready=1 on the first cycle after reset deasserts.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch both masks, starts=0, total=0, round=0; go to EVAL.
- State EVAL (exactly 1 cycle):
  - Matcher inputs are stable from registers.
  - Capture mm_sel_w/a, mm_num, mm_next_w/a into output and next-start registers.
  - total += mm_num; round += 1.
  - Go to PRESENT.
- Last/error determination in EVAL:
  - out_last = mm_last | stall | overrun.
  - stall = (mm_num==0 & ~mm_last).
  - overrun = (round == BITMASK_LENGTH-1) & ~mm_last, evaluated on the pre-increment round value.
  - out_err = stall | overrun.
- State PRESENT:
  - out_valid=1; all out_* registers held stable until out_valid & out_ready.
  - On handshake with out_last: go to IDLE; out_err and out_total hold until the next job's EVAL overwrites them.
  - On handshake without out_last: start_w<=next_w, start_a<=next_a; go to EVAL.
- Latency:
  - Accept edge to first out_valid: 2 cycles.
  - Back-to-back rounds with out_ready held 1: one beat every 2 cycles.
  - Accept of the next job: first cycle after the last handshake (IDLE).
- mm_start_w/a change only on a non-last PRESENT handshake; never while out_valid waits on backpressure.
- mm_num is added zero-extended to TOTAL_BITWIDTH. The matcher contract forbids mm_num > MAX_NUM_OUTPUT; the sequencer does not clamp it.
- in_valid is ignored outside IDLE, and in_bitmask_* is sampled only on the accept edge.
- Reset asserted mid-job (EVAL or PRESENT) aborts immediately with no partial beat completion; after release the block is in IDLE.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Normal single round: MAX_NUM_OUTPUT=4, W=4'b1011, A=4'b1110, bench matcher model -> exactly one beat, 2 cycles after accept: out_sel_w=out_sel_a=4'b1010, out_num=2, out_last=1, out_total=2, out_err=0.
- Multi-round: MAX_NUM_OUTPUT=1, W=A=4'b1111 -> 4 beats; mm_start_w during EVAL = 0,1,2,3; out_num=1 each; out_total 1,2,3,4; out_last only on beat 4.
- Zero match: W=4'b0101, A=4'b1010 -> one beat with out_num=0, out_sel=0, out_last=1, out_total=0, out_err=0; in_ready=1 on the following cycle.
- Backpressure: multi-round case with out_ready=0 for 5 cycles on beat 2 -> out_* and mm_start_* stable across all 5 cycles; in_valid pulses during this window are ignored; the sequence resumes unchanged.
- Protection:
  - Stall: model forces mm_num=0, mm_last=0 -> first beat has out_last=1, out_err=1.
  - Overrun: model forces mm_num=1, mm_last=0 forever -> 4th beat has out_last=1, out_err=1, out_total=4.
- Async reset in PRESENT of beat 2 -> out_valid=0 within the same cycle; after release in_ready=1; a new job W=A=4'b0001 completes with out_total=1.
